write_req_assembler: RTL and testbench
======================================

Name: write_req_assembler

Overview:
- Sits between the cache-side AXI write channels (AW, W) and the per-rank execution units of the memory controller.
- Queues write addresses in a FIFO of decoded WrAddrEntry records and pairs each one with its BURST_LENGTH W beats.
- Emits each paired beat through a one-entry registered output stage. The beat carries the decoded mem_addr_t and is routed one-hot to the rank execution unit chosen by {channel, rank}.
- Also flags AXI write protocol violations.

Parameters:
- DEPTH, ASSEMBLER_DEPTH (8): AW entry FIFO depth; must be a power of two.
- BEATS, BURST_LENGTH (8): W beats per AW request.
- NUNIT, NUM_RANKEXECUTION_UNIT (8): number of rank execution units; equals 1<<(RKWIDTH+CHWIDTH).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- aw_i  in  axi_aw_chan_t  write address (id, addr, user)
- aw_valid_i  in  1  AW valid
- aw_ready_o  out  1  AW ready
- w_i  in  axi_w_chan_t  write beat (data, user, id, last, strb)
- w_valid_i  in  1  W valid
- w_ready_o  out  1  W ready
- req_valid_o  out  NUNIT  one-hot target unit; all zero when no beat is held
- req_mem_addr_o  out  mem_addr_t  decoded address of the burst
- req_addr_o  out  AXI_ADDRWIDTH  raw AXI address
- req_id_o  out  MEM_IDWIDTH  AW id
- req_user_o  out  MEM_USERWIDTH  AW user
- req_data_o  out  MEM_DATAWIDTH  beat data
- req_strb_o  out  MEM_DATAWIDTH/8  beat strobe
- req_beat_o  out  $clog2(BEATS)  beat index within the burst
- req_last_o  out  1  final beat of the burst
- req_ready_i  in  NUNIT  per-unit accept
- occupancy_o  out  $clog2(DEPTH)+1  number of AW entries queued
- proto_err_o  out  1  sticky protocol-error flag

Behaviour:
- Reset (asynchronous, rst_n=0):
  - FIFO pointers, count and beat counter cleared.
  - Output stage emptied: req_valid_o=0; all data outputs 0.
  - aw_ready_o=1, w_ready_o=0, occupancy_o=0, proto_err_o=0.
  - Reset mid-burst discards the partial burst and all queued entries; no beats are emitted after release.
- Address decode (combinational at AW push):
  - mem_addr_t is a direct cast of aw_i.addr: bit31 channel, [30:29] rank, [28:27] bankgroup, [26:25] bank, [24:10] row, [9:0] col.
  - fsm = one-hot(channel*4 + rank).
  - Push stores {mem_addr, fsm, aw_i}.
- AW side:
  - aw_ready_o = (count < DEPTH). It is registered-derived; a same-cycle pop gives no bypass.
  - Push on aw_valid_i & aw_ready_o.
  - Pop when the last beat of the head burst is accepted into the output stage.
  - Simultaneous push and pop leaves count unchanged.
  - occupancy_o = count.
- W side:
  - out_free = !out_valid | (|(req_valid_o & req_ready_i)).
  - w_ready_o = (count != 0) & out_free. W is never accepted before its AW.
  - When the FIFO is empty, w_ready_o=0.
- Beat transfer (w_valid_i & w_ready_o):
  - The output stage loads head.fsm, head.mem_addr, head.aw, w_i.data, w_i.strb and the beat counter value.
  - Latency is 1 cycle from W handshake to req_valid_o.
- Output stage:
  - Holds all outputs stable until the selected unit asserts req_ready_i.
  - Back-to-back beats are sustained at 1 beat per cycle when the unit is ready.
- Beat counter:
  - Counts 0..BEATS-1 on accepted beats and wraps to 0 when the head pops.
  - Terminal beat: counter==BEATS-1 or w_i.last=1.
  - Terminal beat sets req_last_o=1, pops the head and resets the counter.
- Protocol errors (proto_err_o set 1 cycle after detection; cleared only by reset):
  - w_i.last=1 with counter<BEATS-1: early last, burst terminated.
  - w_i.last=0 with counter==BEATS-1: missing last; beat still treated as final.
  - w_i.id != head aw.id.
  - Detection does not stall flow.
- FIFO storage:
  - Read and write pointers of $clog2(DEPTH) bits, wrapping naturally.
  - count is $clog2(DEPTH)+1 bits and distinguishes full from empty.

Decomposition:
- The MemoryController_Definitions package already holds mem_addr_t, WrAddrEntry, axi_aw_chan_t, axi_w_chan_t, ASSEMBLER_DEPTH, BURST_LENGTH and NUM_RANKEXECUTION_UNIT.
- Add to the package: function decode_fsm_onehot(mem_addr_t) returning [NUM_RANKEXECUTION_UNIT-1:0].
- One sub-module: wr_addr_fifo, a generic synchronous FIFO of WrAddrEntry with push, pop, head, count, full and empty.

Test Plan:
- Single burst:
  - Stimulus: AW addr=0xA000_0040, id=3, then 8 W beats data=i, last on beat 7, all units ready.
  - Required: 8 outputs with req_valid_o=8'b0010_0000, req_mem_addr_o.channel=1, rank=1, col=0x040, req_beat_o=0..7, req_last_o only on beat 7, occupancy_o back to 0.
- Backpressure:
  - Stimulus: hold req_ready_i[5]=0 for 4 cycles mid-burst.
  - Required: outputs stable, w_ready_o=0, no beat lost or duplicated; throughput resumes at 1 beat per cycle.
- Full FIFO:
  - Stimulus: 8 AWs with no W.
  - Required: occupancy_o=8, aw_ready_o=0. After one full burst completes, aw_ready_o=1 the next cycle; 9th AW is accepted.
- W before AW:
  - Stimulus: w_valid_i asserted with the FIFO empty.
  - Required: w_ready_o=0 until the AW push; first beat emitted 2 cycles after AW handshake.
- Early last:
  - Stimulus: w_i.last=1 on beat 3.
  - Required: req_last_o=1 on beat 3, proto_err_o=1 the next cycle, next AW's burst starts at req_beat_o=0.
- Reset mid-burst:
  - Stimulus: rst_n low after beat 4 with 3 entries queued.
  - Required: req_valid_o=0, occupancy_o=0, proto_err_o=0, aw_ready_o=1 immediately (asynchronous).

Source files
------------

// File: rtl/write_req_assembler_pkg.sv
// Shared types for the write request assembler: AXI channel records, the decoded
// DRAM address and the queued AW entry, plus the rank-unit one-hot decoder.
package write_req_assembler_pkg;

  localparam int unsigned AXI_ADDRWIDTH          = 32;
  localparam int unsigned MEM_IDWIDTH            = 4;
  localparam int unsigned MEM_USERWIDTH          = 4;
  localparam int unsigned MEM_DATAWIDTH          = 64;
  localparam int unsigned CHWIDTH                = 1;
  localparam int unsigned RKWIDTH                = 2;
  localparam int unsigned BGWIDTH                = 2;
  localparam int unsigned BKWIDTH                = 2;
  localparam int unsigned ROWWIDTH               = 15;
  localparam int unsigned COLWIDTH               = 10;
  localparam int unsigned ASSEMBLER_DEPTH        = 8;
  localparam int unsigned BURST_LENGTH           = 8;
  localparam int unsigned NUM_RANKEXECUTION_UNIT = 1 << (RKWIDTH + CHWIDTH);

  typedef struct packed {
    logic [CHWIDTH-1:0]  channel;
    logic [RKWIDTH-1:0]  rank;
    logic [BGWIDTH-1:0]  bankgroup;
    logic [BKWIDTH-1:0]  bank;
    logic [ROWWIDTH-1:0] row;
    logic [COLWIDTH-1:0] col;
  } mem_addr_t;

  typedef struct packed {
    logic [MEM_IDWIDTH-1:0]   id;
    logic [AXI_ADDRWIDTH-1:0] addr;
    logic [MEM_USERWIDTH-1:0] user;
  } axi_aw_chan_t;

  typedef struct packed {
    logic [MEM_DATAWIDTH-1:0]   data;
    logic [MEM_USERWIDTH-1:0]   user;
    logic [MEM_IDWIDTH-1:0]     id;
    logic                       last;
    logic [MEM_DATAWIDTH/8-1:0] strb;
  } axi_w_chan_t;

  typedef struct packed {
    mem_addr_t                           mem_addr;
    logic [NUM_RANKEXECUTION_UNIT-1:0]   fsm;
    axi_aw_chan_t                        aw;
  } WrAddrEntry;

  typedef enum logic {
    OUT_EMPTY,
    OUT_FULL
  } out_state_e;

  // Rank execution unit index is {channel, rank}.
  function automatic logic [NUM_RANKEXECUTION_UNIT-1:0] decode_fsm_onehot(input mem_addr_t a);
    logic [NUM_RANKEXECUTION_UNIT-1:0] oh;
    oh = '0;
    oh[{a.channel, a.rank}] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/write_req_assembler_if.sv
// AXI write address/data channels as seen by the assembler (slave) and the cache (master).
interface write_req_assembler_if;
  import write_req_assembler_pkg::*;

  axi_aw_chan_t aw_i;
  logic         aw_valid_i;
  logic         aw_ready_o;
  axi_w_chan_t  w_i;
  logic         w_valid_i;
  logic         w_ready_o;

  modport master (output aw_i, aw_valid_i, w_i, w_valid_i, input aw_ready_o, w_ready_o);
  modport slave  (input aw_i, aw_valid_i, w_i, w_valid_i, output aw_ready_o, w_ready_o);
endinterface

// File: rtl/wr_addr_fifo.sv
// Synchronous FIFO of decoded AW entries; count is one bit wider than the pointers
// so full and empty are distinguishable.
module wr_addr_fifo
  import write_req_assembler_pkg::*;
#(
  parameter int unsigned DEPTH = ASSEMBLER_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  WrAddrEntry             push_data_i,
  input  logic                   pop_i,
  output WrAddrEntry             head_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  WrAddrEntry    mem_q [DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [PW:0]   count_q;
  logic          do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PW'(1);
      if (do_pop)  rptr_q <= rptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PW+1)'(1);
        2'b01:   count_q <= count_q - (PW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= push_data_i;
  end

endmodule

// File: rtl/write_req_assembler.sv
// Pairs queued AW entries with their W beats and presents each beat, one-hot routed
// to its rank execution unit, from a single registered output stage.
module write_req_assembler
  import write_req_assembler_pkg::*;
#(
  parameter int unsigned DEPTH = ASSEMBLER_DEPTH,
  parameter int unsigned BEATS = BURST_LENGTH,
  parameter int unsigned NUNIT = NUM_RANKEXECUTION_UNIT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  write_req_assembler_if.slave       axi,
  output logic [NUNIT-1:0]           req_valid_o,
  output mem_addr_t                  req_mem_addr_o,
  output logic [AXI_ADDRWIDTH-1:0]   req_addr_o,
  output logic [MEM_IDWIDTH-1:0]     req_id_o,
  output logic [MEM_USERWIDTH-1:0]   req_user_o,
  output logic [MEM_DATAWIDTH-1:0]   req_data_o,
  output logic [MEM_DATAWIDTH/8-1:0] req_strb_o,
  output logic [$clog2(BEATS)-1:0]   req_beat_o,
  output logic                       req_last_o,
  input  logic [NUNIT-1:0]           req_ready_i,
  output logic [$clog2(DEPTH):0]     occupancy_o,
  output logic                       proto_err_o
);
  localparam int unsigned BW = $clog2(BEATS);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  WrAddrEntry                 push_entry, head;
  logic                       fifo_full, fifo_empty, aw_push, head_pop;
  logic                       w_fire, out_take, out_free, at_last, terminal, err_hit;
  logic                       unused_w_user;
  out_state_e                 state_q, state_d;
  logic [BW-1:0]              beat_q, beat_d;
  logic                       err_q, err_d;
  logic [NUNIT-1:0]           fsm_q;
  mem_addr_t                  maddr_q;
  axi_aw_chan_t               aw_q;
  logic [MEM_DATAWIDTH-1:0]   data_q;
  logic [MEM_DATAWIDTH/8-1:0] strb_q;
  logic [BW-1:0]              obeat_q;
  logic                       last_q;

  assign push_entry.mem_addr = mem_addr_t'(axi.aw_i.addr);
  assign push_entry.fsm      = decode_fsm_onehot(mem_addr_t'(axi.aw_i.addr));
  assign push_entry.aw       = axi.aw_i;

  assign axi.aw_ready_o = ~fifo_full;
  assign aw_push        = axi.aw_valid_i & ~fifo_full;

  assign req_valid_o = (state_q == OUT_FULL) ? fsm_q : '0;
  assign out_take    = |(req_valid_o & req_ready_i);
  assign out_free    = (state_q == OUT_EMPTY) | out_take;
  assign axi.w_ready_o = ~fifo_empty & out_free;
  assign w_fire      = axi.w_valid_i & ~fifo_empty & out_free;

  // A burst ends on the counted final beat or on WLAST, whichever comes first.
  assign at_last  = (beat_q == LAST_BEAT);
  assign terminal = at_last | axi.w_i.last;
  assign head_pop = w_fire & terminal;
  assign err_hit  = (axi.w_i.last != at_last) | (axi.w_i.id != head.aw.id);
  assign unused_w_user = ^axi.w_i.user;

  wr_addr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (aw_push),
    .push_data_i (push_entry),
    .pop_i       (head_pop),
    .head_o      (head),
    .count_o     (occupancy_o),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    err_d   = err_q;
    if (w_fire)        state_d = OUT_FULL;
    else if (out_take) state_d = OUT_EMPTY;
    if (head_pop)      beat_d = '0;
    else if (w_fire)   beat_d = beat_q + BW'(1);
    if (w_fire && err_hit) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= OUT_EMPTY;
      beat_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= '0;
      maddr_q <= '0;
      aw_q    <= '0;
      data_q  <= '0;
      strb_q  <= '0;
      obeat_q <= '0;
      last_q  <= 1'b0;
    end else if (w_fire) begin
      fsm_q   <= NUNIT'(head.fsm);
      maddr_q <= head.mem_addr;
      aw_q    <= head.aw;
      data_q  <= axi.w_i.data;
      strb_q  <= axi.w_i.strb;
      obeat_q <= beat_q;
      last_q  <= terminal;
    end
  end

  assign req_mem_addr_o = maddr_q;
  assign req_addr_o     = aw_q.addr;
  assign req_id_o       = aw_q.id;
  assign req_user_o     = aw_q.user;
  assign req_data_o     = data_q;
  assign req_strb_o     = strb_q;
  assign req_beat_o     = obeat_q;
  assign req_last_o     = last_q;
  assign proto_err_o    = err_q;

endmodule

// File: tb/tb_write_req_assembler.sv
// Randomized bench for write_req_assembler: the expected beat stream is derived from
// the AW/W sequences sent, independent of timing.
module tb_write_req_assembler;
  import write_req_assembler_pkg::*;

  typedef struct packed {
    logic [7:0]  vld;
    logic [31:0] maddr;
    logic [31:0] addr;
    logic [3:0]  id;
    logic [3:0]  user;
    logic [63:0] data;
    logic [7:0]  strb;
    logic [2:0]  beat;
    logic        last;
    logic        err;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  write_req_assembler_if axi_if ();
  logic [7:0]  req_valid, req_ready;
  mem_addr_t   req_mem_addr;
  logic [31:0] req_addr;
  logic [3:0]  req_id, req_user;
  logic [63:0] req_data;
  logic [7:0]  req_strb;
  logic [2:0]  req_beat;
  logic        req_last, proto_err;
  logic [3:0]  occupancy;

  write_req_assembler #(.DEPTH(8), .BEATS(8), .NUNIT(8)) dut (
    .clk(clk), .rst_n(rst_n), .axi(axi_if),
    .req_valid_o(req_valid), .req_mem_addr_o(req_mem_addr), .req_addr_o(req_addr),
    .req_id_o(req_id), .req_user_o(req_user), .req_data_o(req_data), .req_strb_o(req_strb),
    .req_beat_o(req_beat), .req_last_o(req_last), .req_ready_i(req_ready),
    .occupancy_o(occupancy), .proto_err_o(proto_err)
  );

  int checks = 0;
  int errors = 0;
  int unsigned cyc, aw_hs_cyc, w_hs_cyc;
  axi_aw_chan_t aw_pend[$], aw_all[$];
  axi_w_chan_t  w_pend[$], w_all[$];
  beat_t        got[$], exp_q[$];
  int unsigned  got_cyc[$];
  bit           aw_en, w_en, rnd_valid, rnd_ready;
  logic [7:0]   rdy_mask;

  function automatic beat_t cur_out();
    beat_t b;
    b.vld = req_valid; b.maddr = req_mem_addr; b.addr = req_addr; b.id = req_id;
    b.user = req_user; b.data = req_data; b.strb = req_strb; b.beat = req_beat;
    b.last = req_last; b.err = proto_err;
    return b;
  endfunction

  // Expected stream: each AW consumes W beats until beat 7 or WLAST.
  function automatic void build_exp();
    int unsigned wi;
    bit err;
    wi = 0; err = 1'b0;
    exp_q.delete();
    foreach (aw_all[a]) begin
      for (int k = 0; k < 8; k++) begin
        beat_t e;
        axi_w_chan_t w;
        int unit;
        bit fin;
        if (wi >= w_all.size()) break;
        w = w_all[wi]; wi++;
        fin = (k == 7) || w.last;
        if ((w.last != (k == 7)) || (w.id != aw_all[a].id)) err = 1'b1;
        unit = int'(aw_all[a].addr[31]) * 4 + int'(aw_all[a].addr[30:29]);
        e.vld = 8'(1 << unit);
        e.maddr = aw_all[a].addr; e.addr = aw_all[a].addr; e.id = aw_all[a].id;
        e.user = aw_all[a].user; e.data = w.data; e.strb = w.strb;
        e.beat = 3'(k); e.last = fin; e.err = err;
        exp_q.push_back(e);
        if (fin) break;
      end
    end
  endfunction

  task automatic add_burst(input logic [31:0] addr, input logic [3:0] id, input logic [3:0] wid,
                           input int unsigned n, input bit last_final, input logic [63:0] base);
    axi_aw_chan_t a;
    axi_w_chan_t w;
    a.id = id; a.addr = addr; a.user = 4'($urandom);
    aw_pend.push_back(a); aw_all.push_back(a);
    for (int i = 0; i < int'(n); i++) begin
      w.data = base + 64'(i); w.user = 4'($urandom); w.id = wid;
      w.last = (i == int'(n) - 1) && last_final; w.strb = 8'($urandom);
      w_pend.push_back(w); w_all.push_back(w);
    end
  endtask

  task automatic tick();
    bit aw_go, w_go;
    aw_go = aw_en && (aw_pend.size() != 0) && (!rnd_valid || $urandom_range(3) != 0);
    w_go  = w_en && (w_pend.size() != 0) && (!rnd_valid || $urandom_range(3) != 0);
    axi_if.aw_valid_i = aw_go;
    if (aw_go) axi_if.aw_i = aw_pend[0];
    axi_if.w_valid_i = w_go;
    if (w_go) axi_if.w_i = w_pend[0];
    req_ready = rnd_ready ? 8'($urandom) : rdy_mask;
    #2;
    if (aw_go && axi_if.aw_ready_o) begin void'(aw_pend.pop_front()); aw_hs_cyc = cyc; end
    if (w_go && axi_if.w_ready_o) begin void'(w_pend.pop_front()); w_hs_cyc = cyc; end
    if (|(req_valid & req_ready)) begin got.push_back(cur_out()); got_cyc.push_back(cyc); end
    @(negedge clk);
    cyc++;
  endtask

  task automatic drain(input int unsigned limit);
    int unsigned n = 0;
    while (got.size() < exp_q.size() && n < limit) begin tick(); n++; end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    axi_if.aw_valid_i = 1'b0; axi_if.w_valid_i = 1'b0;
    axi_if.aw_i = '0; axi_if.w_i = '0; req_ready = '0;
    aw_pend.delete(); aw_all.delete(); w_pend.delete(); w_all.delete();
    got.delete(); got_cyc.delete(); exp_q.delete();
    aw_en = 1'b1; w_en = 1'b1; rnd_valid = 1'b0; rnd_ready = 1'b0; rdy_mask = '1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    cyc = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (req_valid !== 8'h00) begin errors++; $display("FAIL reset_valid got %h exp 00", req_valid); end
    checks++; if (axi_if.aw_ready_o !== 1'b1) begin errors++; $display("FAIL reset_aw_ready got %b exp 1", axi_if.aw_ready_o); end
    checks++; if (axi_if.w_ready_o !== 1'b0) begin errors++; $display("FAIL reset_w_ready got %b exp 0", axi_if.w_ready_o); end
    checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL reset_occupancy got %0d exp 0", occupancy); end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL reset_proto_err got %b exp 0", proto_err); end
    checks++; if ({req_addr, req_data, req_strb, req_beat, req_last} !== '0) begin
      errors++; $display("FAIL reset_data got %h %h %h %h %b exp 0", req_addr, req_data, req_strb, req_beat, req_last);
    end
  endtask

  task automatic test_single_burst();
    apply_reset();
    add_burst(32'hA000_0040, 4'd3, 4'd3, 8, 1'b1, 64'd0);
    build_exp();
    drain(100);
    repeat (2) tick();
    checks++; if (got.size() != exp_q.size()) begin errors++; $display("FAIL single_count got %0d exp %0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp_q[i]) begin errors++; $display("FAIL single_beat%0d got %h exp %h", i, got[i], exp_q[i]); end
    end
    if (got.size() >= 8) begin
      checks++; if (got[0].vld !== 8'b0010_0000) begin errors++; $display("FAIL single_onehot got %b exp 00100000", got[0].vld); end
      checks++; if (got_cyc[7] - got_cyc[0] != 7) begin errors++; $display("FAIL single_rate got %0d cycles exp 7", got_cyc[7] - got_cyc[0]); end
      checks++; if (got_cyc[0] != aw_hs_cyc + 2) begin errors++; $display("FAIL single_latency got %0d exp %0d", got_cyc[0], aw_hs_cyc + 2); end
    end
    checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL single_occupancy got %0d exp 0", occupancy); end
  endtask

  task automatic test_backpressure();
    beat_t snap;
    int unsigned n = 0;
    apply_reset();
    add_burst(32'hA000_0040, 4'd5, 4'd5, 8, 1'b1, 64'h1000);
    build_exp();
    while (got.size() < 3 && n < 50) begin tick(); n++; end
    snap = cur_out();
    rdy_mask = 8'hDF;
    for (int s = 0; s < 4; s++) begin
      tick();
      checks++; if (cur_out() !== snap) begin errors++; $display("FAIL bp_hold%0d got %h exp %h", s, cur_out(), snap); end
      checks++; if (axi_if.w_ready_o !== 1'b0) begin errors++; $display("FAIL bp_w_ready%0d got %b exp 0", s, axi_if.w_ready_o); end
    end
    rdy_mask = 8'hFF;
    drain(100);
    checks++; if (got.size() != exp_q.size()) begin errors++; $display("FAIL bp_count got %0d exp %0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp_q[i]) begin errors++; $display("FAIL bp_beat%0d got %h exp %h", i, got[i], exp_q[i]); end
    end
    if (got.size() >= 8) begin
      checks++; if (got_cyc[3] - got_cyc[2] != 5) begin errors++; $display("FAIL bp_stall got %0d exp 5", got_cyc[3] - got_cyc[2]); end
      checks++; if (got_cyc[7] - got_cyc[3] != 4) begin errors++; $display("FAIL bp_resume got %0d exp 4", got_cyc[7] - got_cyc[3]); end
    end
  endtask

  task automatic test_full_fifo();
    int unsigned n = 0;
    int unsigned lastw;
    apply_reset();
    for (int b = 0; b < 9; b++) begin
      logic [3:0] id;
      id = 4'($urandom);
      add_burst(32'($urandom), id, id, 8, 1'b1, {$urandom, $urandom});
    end
    build_exp();
    w_en = 1'b0;
    repeat (12) tick();
    checks++; if (occupancy !== 4'd8) begin errors++; $display("FAIL full_occupancy got %0d exp 8", occupancy); end
    checks++; if (axi_if.aw_ready_o !== 1'b0) begin errors++; $display("FAIL full_aw_ready got %b exp 0", axi_if.aw_ready_o); end
    w_en = 1'b1;
    while (w_pend.size() > 64 && n < 100) begin tick(); n++; end
    lastw = w_hs_cyc;
    n = 0;
    while (aw_pend.size() != 0 && n < 20) begin tick(); n++; end
    checks++; if (aw_pend.size() != 0 || aw_hs_cyc != lastw + 1) begin
      errors++; $display("FAIL full_ninth_aw got cycle %0d exp %0d (pending %0d)", aw_hs_cyc, lastw + 1, aw_pend.size());
    end
    drain(400);
    checks++; if (got.size() != exp_q.size()) begin errors++; $display("FAIL full_count got %0d exp %0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp_q[i]) begin errors++; $display("FAIL full_beat%0d got %h exp %h", i, got[i], exp_q[i]); end
    end
  endtask

  task automatic test_w_before_aw();
    apply_reset();
    add_burst(32'h1234_5678, 4'd9, 4'd9, 8, 1'b1, 64'h77);
    build_exp();
    aw_en = 1'b0;
    for (int s = 0; s < 3; s++) begin
      tick();
      checks++; if (axi_if.w_ready_o !== 1'b0) begin errors++; $display("FAIL wfirst_w_ready%0d got %b exp 0", s, axi_if.w_ready_o); end
    end
    aw_en = 1'b1;
    drain(100);
    checks++; if (got.size() != exp_q.size()) begin errors++; $display("FAIL wfirst_count got %0d exp %0d", got.size(), exp_q.size()); end
    if (got.size() != 0) begin
      checks++; if (got_cyc[0] != aw_hs_cyc + 2) begin errors++; $display("FAIL wfirst_latency got %0d exp %0d", got_cyc[0], aw_hs_cyc + 2); end
      checks++; if (got[0] !== exp_q[0]) begin errors++; $display("FAIL wfirst_beat0 got %h exp %h", got[0], exp_q[0]); end
    end
  endtask

  task automatic test_early_last();
    apply_reset();
    add_burst(32'h2000_0400, 4'd2, 4'd2, 4, 1'b1, 64'h50);
    add_burst(32'hC000_0800, 4'd7, 4'd7, 8, 1'b1, 64'h90);
    build_exp();
    drain(100);
    checks++; if (got.size() != exp_q.size()) begin errors++; $display("FAIL early_count got %0d exp %0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp_q[i]) begin errors++; $display("FAIL early_beat%0d got %h exp %h", i, got[i], exp_q[i]); end
    end
    if (got.size() >= 5) begin
      checks++; if (got[3].last !== 1'b1) begin errors++; $display("FAIL early_last got %b exp 1", got[3].last); end
      checks++; if (got[2].err !== 1'b0 || got[3].err !== 1'b1) begin
        errors++; $display("FAIL early_err got %b%b exp 01", got[2].err, got[3].err);
      end
      checks++; if (got[4].beat !== 3'd0) begin errors++; $display("FAIL early_next_beat got %0d exp 0", got[4].beat); end
    end
  endtask

  task automatic test_reset_mid_burst();
    int unsigned n = 0;
    apply_reset();
    add_burst(32'h4000_0000, 4'd1, 4'd2, 8, 1'b1, 64'h0);
    add_burst(32'h6000_0000, 4'd4, 4'd4, 8, 1'b1, 64'h100);
    add_burst(32'hE000_0000, 4'd6, 4'd6, 8, 1'b1, 64'h200);
    while (got.size() < 5 && n < 100) begin tick(); n++; end
    checks++; if (occupancy !== 4'd3) begin errors++; $display("FAIL rmid_pre_occupancy got %0d exp 3", occupancy); end
    checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL rmid_pre_err got %b exp 1", proto_err); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (req_valid !== 8'h00) begin errors++; $display("FAIL rmid_valid got %h exp 00", req_valid); end
    checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL rmid_occupancy got %0d exp 0", occupancy); end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL rmid_err got %b exp 0", proto_err); end
    checks++; if (axi_if.aw_ready_o !== 1'b1) begin errors++; $display("FAIL rmid_aw_ready got %b exp 1", axi_if.aw_ready_o); end
    @(negedge clk);
    aw_pend.delete(); got.delete(); got_cyc.delete();
    rst_n = 1'b1;
    repeat (10) tick();
    checks++; if (got.size() != 0) begin errors++; $display("FAIL rmid_after got %0d beats exp 0", got.size()); end
    checks++; if (axi_if.w_ready_o !== 1'b0) begin errors++; $display("FAIL rmid_w_ready got %b exp 0", axi_if.w_ready_o); end
  endtask

  task automatic test_random();
    apply_reset();
    for (int b = 0; b < 25; b++) begin
      logic [3:0] id, wid;
      int unsigned kind;
      id = 4'($urandom);
      wid = ($urandom_range(7) == 0) ? (id ^ 4'h1) : id;
      kind = $urandom_range(7);
      if (kind == 0)      add_burst(32'($urandom), id, wid, $urandom_range(1, 7), 1'b1, {$urandom, $urandom});
      else if (kind == 1) add_burst(32'($urandom), id, wid, 8, 1'b0, {$urandom, $urandom});
      else                add_burst(32'($urandom), id, wid, 8, 1'b1, {$urandom, $urandom});
    end
    build_exp();
    rnd_valid = 1'b1; rnd_ready = 1'b1;
    drain(5000);
    checks++; if (got.size() != exp_q.size()) begin errors++; $display("FAIL rand_count got %0d exp %0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp_q[i]) begin errors++; $display("FAIL rand_beat%0d got %h exp %h", i, got[i], exp_q[i]); end
    end
    checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL rand_occupancy got %0d exp 0", occupancy); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_burst();
    test_backpressure();
    test_full_fifo();
    test_w_before_aw();
    test_early_last();
    test_reset_mid_burst();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
